spkr_axil_regbank: RTL and testbench
====================================

// Module: spkr_axil_regbank
// PURPOSE
//  Parametrised AXI4-Lite slave register bank; next generation of the speaker peripheral control slave.
//  Generalises the fixed 4x32-bit bank to NUM_REGS registers of 32 or 64 bits, with per-register
//  read-only status mapping, WSTRB byte enables, SLVERR decode, independent AW/W acceptance and
//  per-register write/read strobes to the speaker datapath.
// PARAMETERS
//  C_DATA_WIDTH  32     AXI data width; legal values 32 or 64
//  C_ADDR_WIDTH  6      AXI address width; must be >= log2(NUM_REGS)+log2(C_DATA_WIDTH/8)
//  NUM_REGS      8      number of registers; 1..2^(C_ADDR_WIDTH-log2(C_DATA_WIDTH/8))
//  RO_MASK       8'h80  bit i=1: register i is read-only and reads status_in slice i
//  RESET_VALUE   0      C_DATA_WIDTH-bit reset value of every RW register
// PORTS
//  ACLK           in   1                     clock; all logic on rising edge
//  ARESETN        in   1                     asynchronous active-low reset
//  S_AXI_AWADDR   in   C_ADDR_WIDTH          write address
//  S_AXI_AWPROT   in   3                     ignored
//  S_AXI_AWVALID  in   1                     write address valid
//  S_AXI_AWREADY  out  1                     write address ready
//  S_AXI_WDATA    in   C_DATA_WIDTH          write data
//  S_AXI_WSTRB    in   C_DATA_WIDTH/8        byte enables
//  S_AXI_WVALID   in   1                     write data valid
//  S_AXI_WREADY   out  1                     write data ready
//  S_AXI_BRESP    out  2                     00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1                     write response valid
//  S_AXI_BREADY   in   1                     write response ready
//  S_AXI_ARADDR   in   C_ADDR_WIDTH          read address
//  S_AXI_ARPROT   in   3                     ignored
//  S_AXI_ARVALID  in   1                     read address valid
//  S_AXI_ARREADY  out  1                     read address ready
//  S_AXI_RDATA    out  C_DATA_WIDTH          read data
//  S_AXI_RRESP    out  2                     00 OKAY, 10 SLVERR
//  S_AXI_RVALID   out  1                     read data valid
//  S_AXI_RREADY   in   1                     read data ready
//  reg_out        out  NUM_REGS*C_DATA_WIDTH RW register contents, reg i at slice i; RO slices driven 0
//  reg_wr_pulse   out  NUM_REGS              1-cycle strobe, reg i committed by an OKAY write
//  reg_rd_pulse   out  NUM_REGS              1-cycle strobe, reg i read with OKAY (e.g. FIFO pop)
//  status_in      in   NUM_REGS*C_DATA_WIDTH status values; only RO_MASK slices used
// BEHAVIOUR
//  Reset (ARESETN low, async): all READY/VALID/pulses=0, BRESP=RRESP=0, RDATA=0, RW regs=RESET_VALUE,
//   FSMs to idle, captured address/data discarded. Mid-transaction reset aborts it; no response is issued.
//  Index = ADDR[C_ADDR_WIDTH-1:log2(C_DATA_WIDTH/8)]; low byte-offset bits ignored.
//  Write FSM: W_IDLE, W_ADDR (AW held), W_DATA (W held), W_RESP.
//   AWREADY=1 in W_IDLE/W_DATA; WREADY=1 in W_IDLE/W_ADDR; both 0 in W_RESP and in reset.
//   AW and W handshakes in either order, or in the same cycle. Once both are held, commit on that edge:
//   move to W_RESP, BVALID=1 next cycle.
//   Commit: index<NUM_REGS and not RO: each byte b with WSTRB[b]=1 updated; BRESP=00;
//   reg_wr_pulse[index]=1 for exactly the cycle BVALID first rises (even if WSTRB=0).
//   Index>=NUM_REGS or RO: no register change, no pulse, BRESP=10.
//   BVALID and BRESP hold until BREADY=1. On that edge, return to W_IDLE. Minimum 1 idle cycle between writes.
//  Read FSM: R_IDLE, R_RESP. ARREADY=1 only in R_IDLE.
//   AR handshake: RDATA/RRESP registered from that cycle's state, RVALID=1 next cycle (latency 1).
//   RDATA = status_in slice (RO), register (RW), or 0 with RRESP=10 (index>=NUM_REGS).
//   reg_rd_pulse[index]=1 for the cycle RVALID first rises, OKAY only.
//   RVALID/RDATA/RRESP hold until RREADY=1. On that edge, return to R_IDLE.
//  Read and write channels are independent. Read and write commit on the same edge to the same register:
//   read returns the pre-write value.
//  Any AXI input change while VALID=1 and READY=0 is a master protocol violation; undefined.
// TESTING
//  32-bit, NUM_REGS=8: write 0x0101FFFF..0xBEEF0011 to 0x00,0x04,0x08,0x0C, read back -> equal data, OKAY,
//   one reg_wr_pulse and one reg_rd_pulse per access.
//  W before AW (W 3 cycles early) to 0x10 data 0xDEAD0011 -> WREADY drops after W, BVALID 1 cycle after AW,
//   reg_out[4]=0xDEAD0011.
//  Write 0xFFFFFFFF with WSTRB=4'b0101 to reg 0=0 -> reads 0x00FF00FF. Write 0x1 to 0x1C (RO) ->
//   SLVERR, reg unchanged, no pulse.
//  Read 0x20 (index 8) -> RDATA=0, RRESP=10. Read 0x1C with status_in[7]=0xCAFE0000 -> 0xCAFE0000 OKAY.
//  Hold BREADY/RREADY low 10 cycles -> BVALID/RVALID and data stable, no new AW/W/AR accepted.
//  ARESETN low mid-write (after AW, before W) -> all outputs 0 immediately, regs=RESET_VALUE;
//   next write completes normally. C_DATA_WIDTH=64 rerun of scenario 1 at stride 8.

Source files
------------

// File: rtl/spkr_axil_regbank.sv
// AXI4-Lite slave register bank for the speaker peripheral.
// NUM_REGS registers of C_DATA_WIDTH bits. Registers flagged in RO_MASK read back
// their status_in slice and reject writes. Write strobes are honoured per byte.
// One-cycle write/read strobes tell the speaker datapath which register was touched.
module spkr_axil_regbank #(
  parameter int unsigned                C_DATA_WIDTH = 32,
  parameter int unsigned                C_ADDR_WIDTH = 6,
  parameter int unsigned                NUM_REGS     = 8,
  parameter logic [NUM_REGS-1:0]        RO_MASK      = NUM_REGS'(8'h80),
  parameter logic [C_DATA_WIDTH-1:0]    RESET_VALUE  = '0
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]           S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]           S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]         S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*C_DATA_WIDTH-1:0]  reg_out,
  output logic [NUM_REGS-1:0]               reg_wr_pulse,
  output logic [NUM_REGS-1:0]               reg_rd_pulse,
  input  logic [NUM_REGS*C_DATA_WIDTH-1:0]  status_in
);

  localparam int unsigned STRB_W   = C_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
  localparam int unsigned NSLOT    = 1 << IDX_W;

  // Masks widened to the full decodable index space so any index can be looked up.
  localparam logic [NSLOT-1:0] RO_EXT  = NSLOT'(RO_MASK);
  localparam logic [NSLOT-1:0] PRESENT = NSLOT'({NUM_REGS{1'b1}});
  localparam logic [NSLOT-1:0] RW_EXT  = PRESENT & ~RO_EXT;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_RESP} rstate_t;

  wstate_t                 r_wstate, w_wstate_nxt;
  rstate_t                 r_rstate, w_rstate_nxt;

  logic [C_DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [IDX_W-1:0]        r_awidx;
  logic [C_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]       r_wstrb;
  logic [1:0]              r_bresp;
  logic [NUM_REGS-1:0]     r_wr_pulse;
  logic [C_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]              r_rresp;
  logic [NUM_REGS-1:0]     r_rd_pulse;

  logic                    w_awready, w_wready, w_bvalid;
  logic                    w_arready, w_rvalid;
  logic                    w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [IDX_W-1:0]        w_awidx_in, w_aridx_in, w_cidx;
  logic [C_DATA_WIDTH-1:0] w_cdata, w_rdata_sel;
  logic [STRB_W-1:0]       w_cstrb;
  logic [1:0]              w_rresp_sel;
  logic                    w_unused;

  assign w_awidx_in = S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
  assign w_aridx_in = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];

  assign S_AXI_AWREADY = w_awready;
  assign S_AXI_WREADY  = w_wready;
  assign S_AXI_BVALID  = w_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = w_arready;
  assign S_AXI_RVALID  = w_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign reg_wr_pulse  = r_wr_pulse;
  assign reg_rd_pulse  = r_rd_pulse;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

  // Write channel: ready/valid decode, handshakes and commit selection.
  // The commit takes address/data from the bus when that half arrives on the
  // committing edge, otherwise from the copy captured earlier.
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_awready    = 1'b0;
    w_wready     = 1'b0;
    w_bvalid     = 1'b0;
    w_commit     = 1'b0;
    w_cidx       = r_awidx;
    w_cdata      = r_wdata;
    w_cstrb      = r_wstrb;
    case (r_wstate)
      W_IDLE:  begin w_awready = ARESETN; w_wready = ARESETN; end
      W_ADDR:  w_wready  = ARESETN;
      W_DATA:  w_awready = ARESETN;
      W_RESP:  w_bvalid  = 1'b1;
      default: ;
    endcase
    w_aw_hs = S_AXI_AWVALID && w_awready;
    w_w_hs  = S_AXI_WVALID && w_wready;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_commit     = 1'b1;
          w_cidx       = w_awidx_in;
          w_cdata      = S_AXI_WDATA;
          w_cstrb      = S_AXI_WSTRB;
          w_wstate_nxt = W_RESP;
        end else if (w_aw_hs) begin
          w_wstate_nxt = W_ADDR;
        end else if (w_w_hs) begin
          w_wstate_nxt = W_DATA;
        end
      end
      W_ADDR: begin
        if (w_w_hs) begin
          w_commit     = 1'b1;
          w_cdata      = S_AXI_WDATA;
          w_cstrb      = S_AXI_WSTRB;
          w_wstate_nxt = W_RESP;
        end
      end
      W_DATA: begin
        if (w_aw_hs) begin
          w_commit     = 1'b1;
          w_cidx       = w_awidx_in;
          w_wstate_nxt = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  // Write channel state, captured halves, response code and write strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate   <= W_IDLE;
      r_awidx    <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      if (w_aw_hs) r_awidx <= w_awidx_in;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_commit) r_bresp <= RW_EXT[w_cidx] ? RESP_OKAY : RESP_SLVERR;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_wr_pulse[i] <= w_commit && RW_EXT[i] && (w_cidx == IDX_W'(i));
      end
    end
  end

  // Register storage: byte-masked update of the committed writable register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_commit && RW_EXT[i] && (w_cidx == IDX_W'(i))) begin
          for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_cstrb[b]) r_regs[i][8*b +: 8] <= w_cdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read channel: ready/valid decode and next state.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_arready    = 1'b0;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE:  w_arready = ARESETN;
      R_RESP:  w_rvalid  = 1'b1;
      default: ;
    endcase
    w_ar_hs = S_AXI_ARVALID && w_arready;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_RESP;
      R_RESP:  if (S_AXI_RREADY) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read data select: status slice, stored register, or zero with SLVERR.
  always_comb begin
    w_rdata_sel = '0;
    w_rresp_sel = RESP_SLVERR;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (w_aridx_in == IDX_W'(i)) begin
        w_rresp_sel = RESP_OKAY;
        w_rdata_sel = RO_EXT[i] ? status_in[i*C_DATA_WIDTH +: C_DATA_WIDTH] : r_regs[i];
      end
    end
  end

  // Read channel state, registered response and read strobe.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate   <= R_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_rd_pulse <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rdata_sel;
        r_rresp <= w_rresp_sel;
      end
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_rd_pulse[i] <= w_ar_hs && (w_aridx_in == IDX_W'(i));
      end
    end
  end

  // Register contents to the datapath; read-only slices are forced to zero.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = RO_EXT[i] ? '0 : r_regs[i];
    end
  end

endmodule

// File: tb/tb_spkr_axil_regbank.sv
// Testbench for spkr_axil_regbank: directed table, same-edge read/write,
// mid-transaction reset, randomized traffic against a reference model, and a
// 64-bit instance exercised at 8-byte stride.
module tb_spkr_axil_regbank;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESETN;

  // 32-bit instance signals
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] reg_out, status_in;
  logic [7:0]   wr_pulse, rd_pulse;

  // 64-bit instance signals
  logic [5:0]   x_awaddr, x_araddr;
  logic         x_awvalid, x_awready, x_wvalid, x_wready, x_bvalid, x_bready;
  logic         x_arvalid, x_arready, x_rvalid, x_rready;
  logic [63:0]  x_wdata, x_rdata;
  logic [7:0]   x_wstrb;
  logic [1:0]   x_bresp, x_rresp;
  logic [511:0] x_reg_out, x_status;
  logic [7:0]   x_wr_pulse, x_rd_pulse;

  spkr_axil_regbank #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(6), .NUM_REGS(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_wr_pulse(wr_pulse), .reg_rd_pulse(rd_pulse), .status_in(status_in)
  );

  spkr_axil_regbank #(.C_DATA_WIDTH(64), .C_ADDR_WIDTH(6), .NUM_REGS(8)) dut64 (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(x_awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(x_awvalid), .S_AXI_AWREADY(x_awready),
    .S_AXI_WDATA(x_wdata), .S_AXI_WSTRB(x_wstrb), .S_AXI_WVALID(x_wvalid), .S_AXI_WREADY(x_wready),
    .S_AXI_BRESP(x_bresp), .S_AXI_BVALID(x_bvalid), .S_AXI_BREADY(x_bready),
    .S_AXI_ARADDR(x_araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(x_arvalid), .S_AXI_ARREADY(x_arready),
    .S_AXI_RDATA(x_rdata), .S_AXI_RRESP(x_rresp), .S_AXI_RVALID(x_rvalid), .S_AXI_RREADY(x_rready),
    .reg_out(x_reg_out), .reg_wr_pulse(x_wr_pulse), .reg_rd_pulse(x_rd_pulse), .status_in(x_status)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake did not complete within the cycle budget", nm);
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // ---------------- reference model (32-bit bank) ----------------
  localparam logic [7:0] RO = 8'h80;
  logic [31:0] m_regs [8];

  function automatic logic [1:0] m_wresp(input logic [5:0] a);
    int idx;
    idx = int'(a[5:2]);
    if (idx >= 8) return 2'b10;
    if (RO[idx]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void m_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    idx = int'(a[5:2]);
    if (m_wresp(a) != 2'b00) return;
    for (int b = 0; b < 4; b++)
      if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void m_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(a[5:2]);
    if (idx >= 8) begin d = '0; r = 2'b10; end
    else if (RO[idx]) begin d = status_in[idx*32 +: 32]; r = 2'b00; end
    else begin d = m_regs[idx]; r = 2'b00; end
  endfunction

  function automatic logic [255:0] m_regout();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) if (!RO[i]) v[i*32 +: 32] = m_regs[i];
    return v;
  endfunction

  function automatic logic [7:0] onehot(input logic [5:0] a, input logic [1:0] resp);
    logic [7:0] v;
    v = '0;
    if (resp == 2'b00 && a[5:2] < 4'd8) v[a[4:2]] = 1'b1;
    return v;
  endfunction

  // ---------------- bus tasks (32-bit) ----------------
  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, input int hold, input logic [1:0] eresp);
    bit awd, wd, awh, wh;
    int n;
    logic [7:0] ep;
    awd = 0; wd = 0; n = 0;
    ep = onehot(a, eresp);
    awaddr = a; wdata = d; wstrb = s;
    while (!(awd && wd)) begin
      if (n > 30) begin timeout("write_handshake"); break; end
      awvalid = !awd && (n >= aw_at);
      wvalid  = !wd && (n >= w_at);
      awh = awvalid && awready;
      wh  = wvalid && wready;
      tick;
      n++;
      if (awh) awd = 1;
      if (wh) wd = 1;
      if (wd && !awd) chk("wready_low_after_w", wready, 0);
      if (awd && !wd) chk("awready_low_after_aw", awready, 0);
    end
    awvalid = 0; wvalid = 0;
    chk("bvalid_rise", bvalid, 1);
    chk("bresp", bresp, eresp);
    chk("wr_pulse", wr_pulse, ep);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("bvalid_hold", bvalid, 1);
      chk("bresp_hold", bresp, eresp);
      chk("wr_pulse_once", wr_pulse, 0);
      chk("aw_w_blocked", {awready, wready}, 0);
    end
    bready = 1;
    tick;
    bready = 0;
    chk("bvalid_fall", bvalid, 0);
    chk("wr_pulse_clear", wr_pulse, 0);
  endtask

  task automatic do_read(input logic [5:0] a, input int hold,
                         input logic [1:0] eresp, input logic [31:0] edata);
    bit arh;
    int n;
    logic [7:0] ep;
    n = 0;
    ep = onehot(a, eresp);
    araddr = a;
    arvalid = 1;
    while (1) begin
      if (n > 30) begin timeout("read_handshake"); break; end
      arh = arready;
      tick;
      n++;
      if (arh) break;
    end
    arvalid = 0;
    chk("rvalid_rise", rvalid, 1);
    chk("rresp", rresp, eresp);
    chk("rdata", rdata, edata);
    chk("rd_pulse", rd_pulse, ep);
    for (int h = 0; h < hold; h++) begin
      tick;
      chk("rvalid_hold", rvalid, 1);
      chk("rdata_hold", {rresp, rdata}, {eresp, edata});
      chk("rd_pulse_once", rd_pulse, 0);
      chk("ar_blocked", arready, 0);
    end
    rready = 1;
    tick;
    rready = 0;
    chk("rvalid_fall", rvalid, 0);
    chk("rd_pulse_clear", rd_pulse, 0);
  endtask

  // ---------------- bus tasks (64-bit) ----------------
  task automatic w64(input logic [5:0] a, input logic [63:0] d, input logic [7:0] ep);
    int n;
    n = 0;
    x_awaddr = a; x_wdata = d; x_wstrb = 8'hFF;
    x_awvalid = 1; x_wvalid = 1;
    while (!(x_awready && x_wready)) begin
      if (n > 30) begin timeout("w64_handshake"); break; end
      tick;
      n++;
    end
    tick;
    x_awvalid = 0; x_wvalid = 0;
    chk("w64_bvalid", x_bvalid, 1);
    chk("w64_bresp", x_bresp, 2'b00);
    chk("w64_pulse", x_wr_pulse, ep);
    x_bready = 1;
    tick;
    x_bready = 0;
  endtask

  task automatic r64(input logic [5:0] a, input logic [63:0] ed, input logic [7:0] ep);
    int n;
    n = 0;
    x_araddr = a;
    x_arvalid = 1;
    while (!x_arready) begin
      if (n > 30) begin timeout("r64_handshake"); break; end
      tick;
      n++;
    end
    tick;
    x_arvalid = 0;
    chk("r64_rvalid", x_rvalid, 1);
    chk("r64_rdata", x_rdata, ed);
    chk("r64_rresp", x_rresp, 2'b00);
    chk("r64_pulse", x_rd_pulse, ep);
    x_rready = 1;
    tick;
    x_rready = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_at;
    int          w_at;
    int          hold;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input bit wr, input logic [5:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int aw_at, input int w_at,
                              input int hold, input logic [1:0] resp, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.aw_at = aw_at; v.w_at = w_at;
    v.hold = hold; v.resp = resp; v.rdata = rd;
    return v;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    logic [31:0] ed, old;
    logic [1:0]  er;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  s;

    ARESETN = 0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    x_awaddr = '0; x_awvalid = 0; x_wdata = '0; x_wstrb = '0; x_wvalid = 0; x_bready = 0;
    x_araddr = '0; x_arvalid = 0; x_rready = 0;
    for (int i = 0; i < 8; i++) status_in[i*32 +: 32] = $urandom;
    status_in[7*32 +: 32] = 32'hCAFE0000;
    for (int i = 0; i < 16; i++) x_status[i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) m_regs[i] = '0;

    tick; tick;
    chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, wr_pulse, rd_pulse, rdata}, '0);
    chk("reset_regout", reg_out, '0);
    ARESETN = 1;
    tick;
    chk("idle_ready", {awready, wready, arready, bvalid, rvalid}, 5'b11100);

    tbl.push_back(mk(1, 6'h00, 32'h0101FFFF, 4'hF, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(1, 6'h04, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(1, 6'h08, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(1, 6'h0C, 32'hBEEF0011, 4'hF, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 2'b00, 32'h0101FFFF));
    tbl.push_back(mk(0, 6'h04, 0, 0, 0, 0, 0, 2'b00, 32'h12345678));
    tbl.push_back(mk(0, 6'h08, 0, 0, 0, 0, 0, 2'b00, 32'hA5A5A5A5));
    tbl.push_back(mk(0, 6'h0C, 0, 0, 0, 0, 0, 2'b00, 32'hBEEF0011));
    tbl.push_back(mk(1, 6'h10, 32'hDEAD0011, 4'hF, 3, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 6'h10, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD0011));
    tbl.push_back(mk(1, 6'h18, 32'h00C0FFEE, 4'hF, 0, 2, 0, 2'b00, 0));
    tbl.push_back(mk(0, 6'h1A, 0, 0, 0, 0, 0, 2'b00, 32'h00C0FFEE));
    tbl.push_back(mk(1, 6'h00, 32'h00000000, 4'hF, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(1, 6'h00, 32'hFFFFFFFF, 4'b0101, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 0, 2'b00, 32'h00FF00FF));
    tbl.push_back(mk(1, 6'h1C, 32'h00000001, 4'hF, 0, 0, 0, 2'b10, 0));
    tbl.push_back(mk(0, 6'h1C, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE0000));
    tbl.push_back(mk(0, 6'h20, 0, 0, 0, 0, 0, 2'b10, 32'h00000000));
    tbl.push_back(mk(1, 6'h3E, 32'h00012345, 4'hF, 0, 0, 0, 2'b10, 0));
    tbl.push_back(mk(1, 6'h14, 32'h77777777, 4'hF, 0, 0, 10, 2'b00, 0));
    tbl.push_back(mk(1, 6'h14, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 2'b00, 0));
    tbl.push_back(mk(0, 6'h14, 0, 0, 0, 0, 10, 2'b00, 32'h77777777));

    foreach (tbl[k]) begin
      if (tbl[k].wr) begin
        do_write(tbl[k].addr, tbl[k].data, tbl[k].strb, tbl[k].aw_at, tbl[k].w_at, tbl[k].hold, tbl[k].resp);
        m_write(tbl[k].addr, tbl[k].data, tbl[k].strb);
        chk("reg_out_after_write", reg_out, m_regout());
      end else begin
        do_read(tbl[k].addr, tbl[k].hold, tbl[k].resp, tbl[k].rdata);
      end
    end

    // Read and write to the same register committing on the same edge.
    m_read(6'h0C, old, er);
    awaddr = 6'h0C; wdata = 32'h5555AAAA; wstrb = 4'hF; araddr = 6'h0C;
    awvalid = 1; wvalid = 1; arvalid = 1;
    chk("same_edge_ready", {awready, wready, arready}, 3'b111);
    tick;
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("same_edge_rdata_old", rdata, old);
    chk("same_edge_valids", {bvalid, rvalid, bresp, rresp}, 6'b110000);
    chk("same_edge_pulses", {wr_pulse, rd_pulse}, 16'h0808);
    bready = 1; rready = 1;
    tick;
    bready = 0; rready = 0;
    m_write(6'h0C, 32'h5555AAAA, 4'hF);
    chk("same_edge_regout", reg_out, m_regout());

    // Reset in the middle of a write: address accepted, data never sent.
    awaddr = 6'h08; awvalid = 1;
    tick;
    awvalid = 0;
    chk("mid_write_aw_taken", {awready, wready}, 2'b01);
    ARESETN = 0;
    #1;
    chk("async_reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, wr_pulse, rd_pulse, rdata}, '0);
    chk("async_reset_regout", reg_out, '0);
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    tick; tick;
    chk("reset_no_response", {bvalid, rvalid}, 0);
    ARESETN = 1;
    tick;
    do_write(6'h08, 32'h13572468, 4'hF, 0, 0, 0, 2'b00);
    m_write(6'h08, 32'h13572468, 4'hF);
    chk("post_reset_regout", reg_out, m_regout());
    do_read(6'h08, 0, 2'b00, 32'h13572468);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 80; t++) begin
      a = 6'($urandom_range(0, 39));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom);
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), m_wresp(a));
        m_write(a, d, s);
        chk("rand_regout", reg_out, m_regout());
      end else begin
        m_read(a, ed, er);
        do_read(a, $urandom_range(0, 2), er, ed);
      end
    end

    // 64-bit bank at 8-byte stride.
    w64(6'h00, 64'h0101FFFF_00000001, 8'h01);
    w64(6'h08, 64'h12345678_9ABCDEF0, 8'h02);
    w64(6'h10, 64'hA5A5A5A5_5A5A5A5A, 8'h04);
    w64(6'h18, 64'hBEEF0011_DEADBEEF, 8'h08);
    r64(6'h00, 64'h0101FFFF_00000001, 8'h01);
    r64(6'h08, 64'h12345678_9ABCDEF0, 8'h02);
    r64(6'h10, 64'hA5A5A5A5_5A5A5A5A, 8'h04);
    r64(6'h18, 64'hBEEF0011_DEADBEEF, 8'h08);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
